// File: rtl/graph_resp_pkg.sv
// Shared types and helpers for the graph response compactor family.
// Holds the controller state encoding, default MISR constants and a reference step function.
package graph_resp_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        COMPARE = 2'd2,
        DONE    = 2'd3
    } state_e;

    localparam logic [15:0] POLY_DEFAULT = 16'h1021;
    localparam logic [15:0] SEED_DEFAULT = 16'h0000;

    // One 16-bit MISR step: shift left, apply feedback on the outgoing MSB, fold in the response.
    function automatic logic [15:0] misr_step(input logic [15:0] sig,
                                              input logic [15:0] resp_ext,
                                              input logic [15:0] poly);
        return {sig[14:0], 1'b0} ^ (sig[15] ? poly : 16'h0000) ^ resp_ext;
    endfunction

endpackage

// File: rtl/graph_resp_misr_misr16.sv
// Purely combinational MISR next-state logic, kept separate so a multi-stage compactor can reuse it.
module misr16
    import graph_resp_pkg::*;
#(
    parameter int              SIG_W  = 16,
    parameter int              RESP_W = 9,
    parameter logic [SIG_W-1:0] POLY  = SIG_W'(POLY_DEFAULT)
) (
    input  logic [SIG_W-1:0]  sig,
    input  logic [RESP_W-1:0] resp,
    output logic [SIG_W-1:0]  sig_next
);

    logic [SIG_W-1:0] resp_ext;

    assign resp_ext = SIG_W'(resp);

    // The native 16-bit width goes through the shared package step; other widths use the same rule inline.
    generate
        if (SIG_W == 16) begin : g_w16
            assign sig_next = misr_step(sig, resp_ext, POLY);
        end else begin : g_generic
            assign sig_next = {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? POLY : '0) ^ resp_ext;
        end
    endgenerate

endmodule

// File: rtl/graph_resp_misr.sv
// Response compactor: registers the pattern-stage outputs, folds a programmable window into a MISR
// and compares the result against a golden signature, yielding a sticky pass flag.
module graph_resp_misr
    import graph_resp_pkg::*;
#(
    parameter int               RESP_W = 9,
    parameter int               SIG_W  = 16,
    parameter logic [SIG_W-1:0] POLY   = SIG_W'(POLY_DEFAULT),
    parameter logic [SIG_W-1:0] SEED   = SIG_W'(SEED_DEFAULT),
    parameter int               CNT_W  = 8
) (
    input  logic              blif_clk_net,
    input  logic              blif_reset_net,
    input  logic [RESP_W-1:0] resp_in,
    input  logic              start,
    input  logic              clear,
    input  logic [CNT_W-1:0]  win_len,
    input  logic [SIG_W-1:0]  golden_sig,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [SIG_W-1:0]  sig_out,
    output logic [CNT_W-1:0]  sample_cnt
);

    state_e            state_q, state_d;
    logic [RESP_W-1:0] resp_q;
    logic [SIG_W-1:0]  sig_q, sig_d, sig_fold;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
    logic [CNT_W-1:0]  len_q, len_d;
    logic              pass_q, pass_d;
    logic              fold_en;
    logic              last_fold;

    misr16 #(
        .SIG_W  (SIG_W),
        .RESP_W (RESP_W),
        .POLY   (POLY)
    ) u_misr (
        .sig      (sig_q),
        .resp     (resp_q),
        .sig_next (sig_fold)
    );

    assign cnt_inc   = cnt_q + CNT_W'(1);
    assign fold_en   = (state_q == CAPTURE) && (cnt_q != len_q);
    assign last_fold = (cnt_inc == len_q) || (cnt_q == len_q);

    always_ff @(posedge blif_clk_net or negedge blif_reset_net) begin
        if (!blif_reset_net) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:    if (start) state_d = CAPTURE;
                CAPTURE: if (last_fold) state_d = COMPARE;
                COMPARE: state_d = DONE;
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        busy = (state_q == CAPTURE) || (state_q == COMPARE);
        done = (state_q == DONE);
    end

    // Clear freezes the signature, count and verdict so an aborted window can still be inspected.
    always_comb begin
        sig_d  = sig_q;
        cnt_d  = cnt_q;
        len_d  = len_q;
        pass_d = pass_q;
        if (!clear) begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        sig_d = SEED;
                        cnt_d = '0;
                        len_d = (win_len == '0) ? CNT_W'(1) : win_len;
                    end
                end
                CAPTURE: begin
                    if (fold_en) begin
                        sig_d = sig_fold;
                        cnt_d = cnt_inc;
                    end
                end
                COMPARE: pass_d = (sig_q == golden_sig);
                default: ;
            endcase
        end
    end

    always_ff @(posedge blif_clk_net or negedge blif_reset_net) begin
        if (!blif_reset_net) begin
            resp_q <= '0;
            sig_q  <= '0;
            cnt_q  <= '0;
            len_q  <= '0;
            pass_q <= 1'b0;
        end else begin
            resp_q <= resp_in;
            sig_q  <= sig_d;
            cnt_q  <= cnt_d;
            len_q  <= len_d;
            pass_q <= pass_d;
        end
    end

    assign pass       = pass_q;
    assign sig_out    = sig_q;
    assign sample_cnt = cnt_q;

endmodule
